// File: rtl/fetch_sequencer.sv
// Purpose : instruction-fetch sequencer; owns the PC, addresses imem, loads the IF/ID register.
// Latency : a word at address A is valid in IF/ID one edge after pc_q==A; one bubble after a redirect.
// Backpressure: stall holds PC and IF/ID; flush/redirect/halt insert a bubble instead of a fetch.
//
// Ports:
//   clk, rst                    - rising-edge clock, synchronous active-high reset
//   stall, flush                - hazard controls (hold / squash IF/ID)
//   redirect_valid, redirect_pc - taken branch/jump and its byte target
//   halt_req                    - stop fetching (ebreak/ecall decoded)
//   imem_instr / imem_addr      - combinational instruction memory read port
//   ifid_pc, ifid_instr, ifid_valid - IF/ID register contents
//   misaligned                  - sticky flag for a redirect target with bits[1:0] != 0
//   fetch_count                 - count of valid IF/ID loads (wraps)
//   state                       - 00 BOOT, 01 RUN, 10 HALT
module fetch_sequencer #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 64,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               BOOT_CYCLES = 2,
    parameter logic [WIDTH-1:0] NOP         = 'h13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    input  logic [WIDTH-1:0] imem_instr,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] ifid_pc,
    output logic [WIDTH-1:0] ifid_instr,
    output logic             ifid_valid,
    output logic             misaligned,
    output logic [31:0]      fetch_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Byte limit held at 64 bits so DEPTH*4 == 2^WIDTH still compares correctly.
    localparam logic [63:0] LIMIT     = 64'(DEPTH) * 64'd4;
    localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [3:0]       boot_cnt;

    logic pc_in_range;
    logic rd_aligned;
    logic rd_in_range;

    assign pc_in_range = (64'(pc_q) < LIMIT);
    assign rd_aligned  = (redirect_pc[1:0] == 2'b00);
    assign rd_in_range = (64'(redirect_pc) < LIMIT);

    assign imem_addr = pc_q;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            boot_cnt    <= 4'd0;
            ifid_pc     <= '0;
            ifid_instr  <= NOP;
            ifid_valid  <= 1'b0;
            misaligned  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // Requests are ignored until the boot hold-off expires.
                    if (boot_cnt == BOOT_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end

                ST_RUN: begin
                    if (redirect_valid && rd_aligned) begin
                        // Taken branch beats stall and flush: the wrong-path word is dropped.
                        pc_q       <= redirect_pc;
                        ifid_pc    <= '0;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        misaligned <= 1'b1;
                        state_q    <= ST_HALT;
                        ifid_pc    <= '0;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                    end else if (!pc_in_range) begin
                        // Never present an out-of-range word as a real instruction.
                        state_q    <= ST_HALT;
                        ifid_pc    <= '0;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                    end else if (halt_req) begin
                        state_q    <= ST_HALT;
                        ifid_pc    <= '0;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                    end else if (flush) begin
                        ifid_pc    <= '0;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                        if (!stall) begin
                            pc_q <= pc_q + WIDTH'(4);
                        end
                    end else if (!stall) begin
                        ifid_pc     <= pc_q;
                        ifid_instr  <= imem_instr;
                        ifid_valid  <= 1'b1;
                        pc_q        <= pc_q + WIDTH'(4);
                        fetch_count <= fetch_count + 32'd1;
                    end
                end

                ST_HALT: begin
                    // IF/ID already holds the bubble; only a redirect can leave HALT.
                    if (redirect_valid) begin
                        if (!rd_aligned) begin
                            misaligned <= 1'b1;
                        end else if (rd_in_range) begin
                            pc_q    <= redirect_pc;
                            state_q <= ST_RUN;
                        end
                    end
                end

                default: begin
                    state_q    <= ST_HALT;
                    ifid_pc    <= '0;
                    ifid_instr <= NOP;
                    ifid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] NOPW = 32'h00000013;
    localparam logic [31:0] W0   = 32'h00500093;
    localparam logic [31:0] W1   = 32'h00a00113;
    localparam logic [31:0] W2   = 32'h002081b3;
    localparam logic [31:0] W3   = 32'h40110233;
    localparam logic [31:0] BAD  = 32'hdeadbeef;

    localparam logic [1:0] BOOT = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HALT = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        misaligned;
    logic [31:0] fetch_count;
    logic [1:0]  state;

    typedef struct {
        int          idx;
        logic [1:0]  st;
        logic [31:0] pc;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    // Four-word instruction memory; anything past it reads as garbage.
    always_comb begin
        case (imem_addr)
            32'h0:   imem_instr = W0;
            32'h4:   imem_instr = W1;
            32'h8:   imem_instr = W2;
            32'hc:   imem_instr = W3;
            default: imem_instr = BAD;
        endcase
    end

    fetch_sequencer #(
        .WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .BOOT_CYCLES(2), .NOP(32'h00000013)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .imem_instr(imem_instr), .imem_addr(imem_addr),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .misaligned(misaligned), .fetch_count(fetch_count), .state(state)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, expv);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("state",       e.idx, {30'd0, state},      {30'd0, e.st});
                chk("pc_q",        e.idx, imem_addr,           e.pc);
                chk("ifid_valid",  e.idx, {31'd0, ifid_valid}, {31'd0, e.vld});
                chk("ifid_pc",     e.idx, ifid_pc,             e.ipc);
                chk("ifid_instr",  e.idx, ifid_instr,          e.instr);
                chk("misaligned",  e.idx, {31'd0, misaligned}, {31'd0, e.mis});
                chk("fetch_count", e.idx, fetch_count,         e.cnt);
            end
        end
    end

    // Drive inputs on the falling edge and queue what the next rising edge must produce.
    task automatic step(
        input logic r, input logic s, input logic f, input logic rv,
        input logic [31:0] rpc, input logic h,
        input logic [1:0] est, input logic [31:0] epc, input logic ev,
        input logic [31:0] eipc, input logic [31:0] einstr,
        input logic emis, input logic [31:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
        step_no++;
        e.idx = step_no; e.st = est; e.pc = epc; e.vld = ev; e.ipc = eipc;
        e.instr = einstr; e.mis = emis; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //    rst s f rv rpc    h    state pc     v  ipc    instr mis cnt
        step(1, 0,0,0, 32'h0,  0,   BOOT, 32'h0, 0, 32'h0, NOPW, 0, 0);
        // Requests during BOOT are ignored.
        step(0, 0,0,1, 32'h8,  1,   BOOT, 32'h0, 0, 32'h0, NOPW, 0, 0);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h0, 0, 32'h0, NOPW, 0, 0);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h4, 1, 32'h0, W0,   0, 1);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h8, 1, 32'h4, W1,   0, 2);
        // Stall for two cycles holding (4,W1).
        step(0, 1,0,0, 32'h0,  0,   RUN,  32'h8, 1, 32'h4, W1,   0, 2);
        step(0, 1,0,0, 32'h0,  0,   RUN,  32'h8, 1, 32'h4, W1,   0, 2);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'hc, 1, 32'h8, W2,   0, 3);
        // Redirect wins over stall and flush, then target arrives.
        step(0, 1,1,1, 32'hc,  0,   RUN,  32'hc, 0, 32'h0, NOPW, 0, 3);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h10,1, 32'hc, W3,   0, 4);
        // Out of range: bubble and HALT.
        step(0, 0,0,0, 32'h0,  0,   HALT, 32'h10,0, 32'h0, NOPW, 0, 4);
        step(0, 1,1,0, 32'h0,  0,   HALT, 32'h10,0, 32'h0, NOPW, 0, 4);
        // Redirect out of HALT, next edge fetches.
        step(0, 0,0,1, 32'h4,  0,   RUN,  32'h4, 0, 32'h0, NOPW, 0, 4);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h8, 1, 32'h4, W1,   0, 5);
        // Flush advances PC, flush+stall holds PC.
        step(0, 0,1,0, 32'h0,  0,   RUN,  32'hc, 0, 32'h0, NOPW, 0, 5);
        step(0, 1,1,0, 32'h0,  0,   RUN,  32'hc, 0, 32'h0, NOPW, 0, 5);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h10,1, 32'hc, W3,   0, 6);
        // Misaligned redirect halts and sets the sticky flag.
        step(0, 0,0,1, 32'h6,  0,   HALT, 32'h10,0, 32'h0, NOPW, 1, 6);
        step(0, 0,0,1, 32'h6,  0,   HALT, 32'h10,0, 32'h0, NOPW, 1, 6);
        step(1, 0,0,0, 32'h0,  0,   BOOT, 32'h0, 0, 32'h0, NOPW, 0, 0);
        step(0, 0,0,0, 32'h0,  0,   BOOT, 32'h0, 0, 32'h0, NOPW, 0, 0);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h0, 0, 32'h0, NOPW, 0, 0);
        step(0, 0,0,0, 32'h0,  0,   RUN,  32'h4, 1, 32'h0, W0,   0, 1);
        // One-cycle halt_req, HALT holds, then reset with stall high.
        step(0, 0,0,0, 32'h0,  1,   HALT, 32'h4, 0, 32'h0, NOPW, 0, 1);
        step(0, 0,0,0, 32'h0,  0,   HALT, 32'h4, 0, 32'h0, NOPW, 0, 1);
        step(1, 1,0,0, 32'h0,  0,   BOOT, 32'h0, 0, 32'h0, NOPW, 0, 0);

        @(negedge clk);
        rst = 0; stall = 0;
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
